video_dma_rd_sched: RTL and testbench
=====================================

// Module: video_dma_rd_sched
// PURPOSE
//  Read-side scheduler between the pcie_fifo read port and the PCIe DMA engine's per-beat
//  read strobe. Aligns the DMA stream to frame starts and flushes the FIFO while disarmed.
//  Grants FIFO reads only in whole bursts that the FIFO level can cover; otherwise returns a
//  fill pattern. Exposes frame, underrun and resync counters for the host BAR.
//  Lives in the pclk_div2 domain next to ipsl_pcie_dma.
// PARAMETERS
//  BEAT_W        128          data beat width
//  LVL_W         10           width of fifo_rd_level
//  BURST_LEN     16           beats per granted burst (>=2)
//  LVL_MARGIN    2            extra level required, covers FIFO level-update lag
//  FRAME_BEATS   115200       beats per frame (1280x720x16b / 128b)
//  FILL_PAT      {8{16'hCCCC}} data returned for ungranted reads
// PORTS
//  clk            in   1       pclk_div2
//  rst            in   1       synchronous, active-high
//  arm            in   1       host enable; 0 = idle and flush
//  frame_sync     in   1       1-cycle start-of-frame pulse, already in clk domain
//  fifo_ovf       in   1       write-side overflow flag, already in clk domain
//  fifo_rd_level  in   LVL_W   FIFO read water level
//  fifo_rd_en     out  1       FIFO read enable
//  fifo_rd_data   in   BEAT_W  FIFO read data, valid 1 cycle after fifo_rd_en
//  fifo_rst       out  1       FIFO reset (both sides)
//  host_rd_req    in   1       DMA beat read strobe
//  host_rd_data   out  BEAT_W  registered; answers the host_rd_req of the previous cycle
//  state_o        out  2       current FSM state
//  frame_cnt      out  16      completed frames, saturating
//  underrun_cnt   out  16      host reads answered with FILL_PAT while armed, saturating
//  resync_cnt     out  16      misaligned frame_sync or fifo_ovf events, saturating
// BEHAVIOUR
//  Reset values:
//   - state IDLE; fifo_rst=1; fifo_rd_en=0.
//   - host_rd_data=FILL_PAT.
//   - all counters, beat_cnt and burst_cnt = 0.
//  States:
//   - IDLE: fifo_rst=1. arm=1 -> SYNC.
//   - SYNC: fifo_rst=1 until frame_sync. On frame_sync: fifo_rst=0 next cycle; beat_cnt=0; go FILL.
//   - FILL: no grants. fifo_rd_level >= BURST_LEN+LVL_MARGIN -> STREAM with burst_cnt=0.
//   - STREAM:
//     - fifo_rd_en = host_rd_req (combinational).
//     - Each grant increments burst_cnt and beat_cnt.
//     - After the BURST_LEN-th grant: level < BURST_LEN+LVL_MARGIN -> FILL; else stay, burst_cnt=0.
//     - Grant with beat_cnt==FRAME_BEATS-1: frame_cnt++, beat_cnt=0, go FILL (burst end implied).
//  Frame alignment:
//   - frame_sync in FILL/STREAM with beat_cnt==0 is accepted; no action.
//   - Otherwise: resync_cnt++, go SYNC; fifo_rst=1 the next cycle.
//   - frame_sync coincident with a grant: the grant is served first, then the check applies
//     to the pre-grant beat_cnt.
//  Overflow: fifo_ovf=1 in any armed state -> resync_cnt++, go SYNC.
//   - Simultaneous ovf + misaligned sync counts once.
//  Data path:
//   - The grant flag is registered one cycle.
//   - host_rd_data = granted ? fifo_rd_data : FILL_PAT.
//  Underrun: host_rd_req with no grant in SYNC/FILL/STREAM -> underrun_cnt++.
//   - Reads in IDLE are not counted.
//  arm=0 in any state: IDLE next cycle.
//   - An in-flight granted beat is still returned.
//   - Partial beat_cnt is discarded.
//  Counters stick at 16'hFFFF. beat_cnt width = $clog2(FRAME_BEATS).
//  rst mid-operation: all outputs return to reset values next cycle; no grant issued that cycle.
// STRUCTURE
//  video_pcie_pkg contains:
//   - state enum: IDLE=0, SYNC=1, FILL=2, STREAM=3
//   - default FILL_PAT and FRAME_BEATS constants
//  One sub-module: vps_sat_cnt (16-bit saturating counter with sync clear), instanced 3x.
// TESTING
//  1. arm=1, frame_sync, level=18, 16 host reads -> 16 fifo_rd_en; data returned 1 cycle later
//     matches FIFO; level=10 at burst end -> FILL.
//  2. In FILL, level=5, 3 host reads -> 3 x FILL_PAT, underrun_cnt=3, fifo_rd_en stays 0.
//  3. FRAME_BEATS=32, BURST_LEN=16, level high, 32 reads -> frame_cnt=1, beat_cnt=0.
//     Next frame_sync -> resync_cnt stays 0.
//  4. frame_sync at beat_cnt=7 -> resync_cnt=1, state SYNC, fifo_rst=1 next cycle.
//  5. fifo_ovf during STREAM together with misaligned frame_sync -> resync_cnt +1 only.
//  6. arm=0 mid-burst with a grant in flight -> FIFO data still returned; IDLE; fifo_rst=1.
//     rst mid-STREAM -> all reset values.

Source files
------------

// File: rtl/video_pcie_pkg.sv
// Shared types and defaults for the PCIe video DMA read-side scheduler.
package video_pcie_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        FILL   = 2'd2,
        STREAM = 2'd3
    } vps_state_e;

    // 1280x720 pixels at 16 bits, packed into 128-bit beats
    localparam int             DEF_FRAME_BEATS = 115200;
    localparam logic [127:0]   DEF_FILL_PAT    = {8{16'hCCCC}};

endpackage

// File: rtl/vps_sat_cnt.sv
// 16-bit event counter that sticks at all-ones; clr is a synchronous clear.
module vps_sat_cnt (
    input  logic        clk,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_d;
    logic [15:0] cnt_q;

    // Next count: step on inc unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/video_dma_rd_sched.sv
// Read-side scheduler between pcie_fifo and the DMA per-beat read strobe: frame alignment,
// burst-granular grants against the FIFO level, fill-pattern substitution and host counters.
module video_dma_rd_sched
    import video_pcie_pkg::*;
#(
    parameter int                BEAT_W      = 128,
    parameter int                LVL_W       = 10,
    parameter int                BURST_LEN   = 16,
    parameter int                LVL_MARGIN  = 2,
    parameter int                FRAME_BEATS = DEF_FRAME_BEATS,
    parameter logic [BEAT_W-1:0] FILL_PAT    = DEF_FILL_PAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              frame_sync,
    input  logic              fifo_ovf,
    input  logic [LVL_W-1:0]  fifo_rd_level,
    output logic              fifo_rd_en,
    input  logic [BEAT_W-1:0] fifo_rd_data,
    output logic              fifo_rst,
    input  logic              host_rd_req,
    output logic [BEAT_W-1:0] host_rd_data,
    output logic [1:0]        state_o,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       underrun_cnt,
    output logic [15:0]       resync_cnt
);

    localparam int               BEAT_CW    = $clog2(FRAME_BEATS);
    localparam int               BURST_CW   = $clog2(BURST_LEN);
    localparam logic [LVL_W-1:0] LVL_THRESH = LVL_W'(BURST_LEN + LVL_MARGIN);
    localparam logic [BEAT_CW-1:0]  LAST_BEAT  = BEAT_CW'(FRAME_BEATS - 1);
    localparam logic [BURST_CW-1:0] LAST_BURST = BURST_CW'(BURST_LEN - 1);

    vps_state_e          state_d, state_q;
    logic [BEAT_CW-1:0]  beat_cnt_d, beat_cnt_q;
    logic [BURST_CW-1:0] burst_cnt_d, burst_cnt_q;
    logic                fifo_rst_d, fifo_rst_q;
    logic                grant_d, grant_q;
    logic                frame_inc_s;
    logic                underrun_inc_s;
    logic                resync_inc_s;
    logic                armed_s;
    logic                sync_err_s;
    logic                level_ok_s;

    assign armed_s    = (state_q != IDLE);
    assign level_ok_s = (fifo_rd_level >= LVL_THRESH);
    // The alignment check uses the pre-grant beat count, so a coincident grant never masks it
    assign sync_err_s = frame_sync && ((state_q == FILL) || (state_q == STREAM))
                        && (beat_cnt_q != {BEAT_CW{1'b0}});

    // Next-state, burst/beat bookkeeping and counter strobes
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        burst_cnt_d    = burst_cnt_q;
        frame_inc_s    = 1'b0;
        resync_inc_s   = 1'b0;
        grant_d        = (state_q == STREAM) && host_rd_req && arm && !rst;
        underrun_inc_s = armed_s && arm && host_rd_req && !grant_d;

        if (!arm) begin
            state_d     = IDLE;
            beat_cnt_d  = {BEAT_CW{1'b0}};
            burst_cnt_d = {BURST_CW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                end
                SYNC: begin
                    if (frame_sync) begin
                        beat_cnt_d = {BEAT_CW{1'b0}};
                        state_d    = FILL;
                    end else begin
                        state_d = SYNC;
                    end
                end
                FILL: begin
                    if (level_ok_s) begin
                        burst_cnt_d = {BURST_CW{1'b0}};
                        state_d     = STREAM;
                    end else begin
                        state_d = FILL;
                    end
                end
                STREAM: begin
                    if (!grant_d) begin
                        state_d = STREAM;
                    end else if (beat_cnt_q == LAST_BEAT) begin
                        // Frame end also closes the current burst
                        frame_inc_s = 1'b1;
                        beat_cnt_d  = {BEAT_CW{1'b0}};
                        burst_cnt_d = {BURST_CW{1'b0}};
                        state_d     = FILL;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_CW'(1);
                        if (burst_cnt_q == LAST_BURST) begin
                            burst_cnt_d = {BURST_CW{1'b0}};
                            state_d     = level_ok_s ? STREAM : FILL;
                        end else begin
                            burst_cnt_d = burst_cnt_q + BURST_CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if ((fifo_ovf && armed_s) || sync_err_s) begin
                resync_inc_s = 1'b1;
                beat_cnt_d   = {BEAT_CW{1'b0}};
                burst_cnt_d  = {BURST_CW{1'b0}};
                state_d      = SYNC;
            end else begin
                resync_inc_s = 1'b0;
            end
        end

        fifo_rst_d = (state_d == IDLE) || (state_d == SYNC);
    end

    // State, bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= {BEAT_CW{1'b0}};
            burst_cnt_q <= {BURST_CW{1'b0}};
            fifo_rst_q  <= 1'b1;
            grant_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            fifo_rst_q  <= fifo_rst_d;
            grant_q     <= grant_d;
        end
    end

    assign fifo_rd_en   = grant_d;
    assign fifo_rst     = fifo_rst_q;
    assign state_o      = state_q;
    // FIFO data lands one cycle after the read enable, aligned with the registered grant
    assign host_rd_data = grant_q ? fifo_rd_data : FILL_PAT;

    vps_sat_cnt u_frame_cnt (
        .clk (clk),
        .clr (rst),
        .inc (frame_inc_s),
        .cnt (frame_cnt)
    );

    vps_sat_cnt u_underrun_cnt (
        .clk (clk),
        .clr (rst),
        .inc (underrun_inc_s),
        .cnt (underrun_cnt)
    );

    vps_sat_cnt u_resync_cnt (
        .clk (clk),
        .clr (rst),
        .inc (resync_inc_s),
        .cnt (resync_cnt)
    );

endmodule

// File: tb/tb_video_dma_rd_sched.sv
// Directed bench for video_dma_rd_sched with a short 32-beat frame and a counting FIFO model.
module tb_video_dma_rd_sched;

    localparam logic [127:0] FILL_PAT = {8{16'hCCCC}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         arm = 1'b0;
    logic         frame_sync = 1'b0;
    logic         fifo_ovf = 1'b0;
    logic [9:0]   fifo_rd_level = 10'd0;
    logic         fifo_rd_en;
    logic [127:0] fifo_rd_data = 128'd0;
    logic         fifo_rst;
    logic         host_rd_req = 1'b0;
    logic [127:0] host_rd_data;
    logic [1:0]   state_o;
    logic [15:0]  frame_cnt;
    logic [15:0]  underrun_cnt;
    logic [15:0]  resync_cnt;

    int checks = 0;
    int failures = 0;
    int pop_cnt = 0;
    int exp_idx = 0;

    always #5 clk = ~clk;

    video_dma_rd_sched #(
        .FRAME_BEATS (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .frame_sync    (frame_sync),
        .fifo_ovf      (fifo_ovf),
        .fifo_rd_level (fifo_rd_level),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rst      (fifo_rst),
        .host_rd_req   (host_rd_req),
        .host_rd_data  (host_rd_data),
        .state_o       (state_o),
        .frame_cnt     (frame_cnt),
        .underrun_cnt  (underrun_cnt),
        .resync_cnt    (resync_cnt)
    );

    function automatic logic [127:0] fdata(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 | 32'(i);
        return {w, ~w, w, ~w};
    endfunction

    // FIFO read port model: registered data, one word per read enable
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fdata(pop_cnt);
            pop_cnt      <= pop_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++;
        if (fifo_rst !== 1'b1) begin failures++; $display("FAIL reset_fifo_rst: got %b expected 1", fifo_rst); end
        checks++;
        if (host_rd_data !== FILL_PAT) begin failures++; $display("FAIL reset_data: got %h expected %h", host_rd_data, FILL_PAT); end
        checks++;
        if ({frame_cnt, underrun_cnt, resync_cnt} !== 48'h0) begin
            failures++; $display("FAIL reset_counters: got %h expected 0", {frame_cnt, underrun_cnt, resync_cnt});
        end
        host_rd_req = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL idle_rd_en: got %b expected 0", fifo_rd_en); end
        tick();
        host_rd_req = 1'b0;
        checks++;
        if (underrun_cnt !== 16'd0) begin failures++; $display("FAIL idle_underrun: got %0d expected 0", underrun_cnt); end
    endtask

    task automatic test_burst();
        arm = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd1 || fifo_rst !== 1'b1) begin
            failures++; $display("FAIL arm_sync: got state %0d rst %b expected 1/1", state_o, fifo_rst);
        end
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        checks++;
        if (state_o !== 2'd2 || fifo_rst !== 1'b0) begin
            failures++; $display("FAIL sync_fill: got state %0d rst %b expected 2/0", state_o, fifo_rst);
        end
        fifo_rd_level = 10'd18;
        tick();
        checks++;
        if (state_o !== 2'd3) begin failures++; $display("FAIL fill_stream: got %0d expected 3", state_o); end
        for (int i = 0; i < 16; i++) begin
            host_rd_req = 1'b1;
            if (i == 15) fifo_rd_level = 10'd10;
            #1;
            checks++;
            if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL burst_rd_en[%0d]: got %b expected 1", i, fifo_rd_en); end
            tick();
            checks++;
            if (host_rd_data !== fdata(exp_idx)) begin
                failures++; $display("FAIL burst_data[%0d]: got %h expected %h", i, host_rd_data, fdata(exp_idx));
            end
            exp_idx++;
        end
        host_rd_req = 1'b0;
        checks++;
        if (state_o !== 2'd2) begin failures++; $display("FAIL burst_end_fill: got %0d expected 2", state_o); end
    endtask

    task automatic test_underrun();
        fifo_rd_level = 10'd5;
        for (int i = 0; i < 3; i++) begin
            host_rd_req = 1'b1;
            #1;
            checks++;
            if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL fill_rd_en[%0d]: got %b expected 0", i, fifo_rd_en); end
            tick();
            checks++;
            if (host_rd_data !== FILL_PAT) begin failures++; $display("FAIL fill_data[%0d]: got %h expected %h", i, host_rd_data, FILL_PAT); end
        end
        host_rd_req = 1'b0;
        checks++;
        if (underrun_cnt !== 16'd3 || state_o !== 2'd2) begin
            failures++; $display("FAIL underrun_cnt: got %0d state %0d expected 3/2", underrun_cnt, state_o);
        end
    endtask

    task automatic test_frame_end();
        fifo_rd_level = 10'd100;
        tick();
        checks++;
        if (state_o !== 2'd3) begin failures++; $display("FAIL frame_stream: got %0d expected 3", state_o); end
        for (int i = 0; i < 16; i++) begin
            host_rd_req = 1'b1;
            tick();
            checks++;
            if (host_rd_data !== fdata(exp_idx)) begin
                failures++; $display("FAIL frame_data[%0d]: got %h expected %h", i, host_rd_data, fdata(exp_idx));
            end
            exp_idx++;
        end
        host_rd_req = 1'b0;
        checks++;
        if (frame_cnt !== 16'd1 || state_o !== 2'd2) begin
            failures++; $display("FAIL frame_cnt: got %0d state %0d expected 1/2", frame_cnt, state_o);
        end
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        checks++;
        if (resync_cnt !== 16'd0 || state_o !== 2'd3) begin
            failures++; $display("FAIL aligned_sync: got resync %0d state %0d expected 0/3", resync_cnt, state_o);
        end
    endtask

    task automatic test_misaligned();
        for (int i = 0; i < 7; i++) begin
            host_rd_req = 1'b1;
            tick();
            checks++;
            if (host_rd_data !== fdata(exp_idx)) begin
                failures++; $display("FAIL mis_data[%0d]: got %h expected %h", i, host_rd_data, fdata(exp_idx));
            end
            exp_idx++;
        end
        host_rd_req = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        checks++;
        if (resync_cnt !== 16'd1 || state_o !== 2'd1 || fifo_rst !== 1'b1) begin
            failures++; $display("FAIL misaligned: got resync %0d state %0d rst %b expected 1/1/1", resync_cnt, state_o, fifo_rst);
        end
    endtask

    task automatic test_ovf_and_sync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        checks++;
        if (state_o !== 2'd3) begin failures++; $display("FAIL ovf_stream: got %0d expected 3", state_o); end
        for (int i = 0; i < 3; i++) begin
            host_rd_req = 1'b1;
            tick();
            exp_idx++;
        end
        host_rd_req = 1'b0;
        fifo_ovf = 1'b1;
        frame_sync = 1'b1;
        tick();
        fifo_ovf = 1'b0;
        frame_sync = 1'b0;
        checks++;
        if (resync_cnt !== 16'd2 || state_o !== 2'd1 || fifo_rst !== 1'b1) begin
            failures++; $display("FAIL ovf_once: got resync %0d state %0d rst %b expected 2/1/1", resync_cnt, state_o, fifo_rst);
        end
    endtask

    task automatic test_disarm();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        host_rd_req = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL disarm_rd_en: got %b expected 1", fifo_rd_en); end
        tick();
        host_rd_req = 1'b0;
        arm = 1'b0;
        #1;
        checks++;
        if (host_rd_data !== fdata(exp_idx)) begin
            failures++; $display("FAIL disarm_inflight: got %h expected %h", host_rd_data, fdata(exp_idx));
        end
        exp_idx++;
        tick();
        checks++;
        if (state_o !== 2'd0 || fifo_rst !== 1'b1 || host_rd_data !== FILL_PAT) begin
            failures++; $display("FAIL disarm_idle: got state %0d rst %b data %h expected 0/1/fill", state_o, fifo_rst, host_rd_data);
        end
        checks++;
        if (frame_cnt !== 16'd1 || underrun_cnt !== 16'd3) begin
            failures++; $display("FAIL disarm_counters: got frame %0d underrun %0d expected 1/3", frame_cnt, underrun_cnt);
        end
    endtask

    task automatic test_rst_mid_stream();
        arm = 1'b1;
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        checks++;
        if (state_o !== 2'd3) begin failures++; $display("FAIL rst_pre_stream: got %0d expected 3", state_o); end
        host_rd_req = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rst_no_grant: got %b expected 0", fifo_rd_en); end
        tick();
        rst = 1'b0;
        host_rd_req = 1'b0;
        arm = 1'b0;
        checks++;
        if (state_o !== 2'd0 || fifo_rst !== 1'b1 || host_rd_data !== FILL_PAT) begin
            failures++; $display("FAIL rst_outputs: got state %0d rst %b data %h expected 0/1/fill", state_o, fifo_rst, host_rd_data);
        end
        checks++;
        if ({frame_cnt, underrun_cnt, resync_cnt} !== 48'h0) begin
            failures++; $display("FAIL rst_counters: got %h expected 0", {frame_cnt, underrun_cnt, resync_cnt});
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_underrun();
        test_frame_end();
        test_misaligned();
        test_ovf_and_sync();
        test_disarm();
        test_rst_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
